// File: rtl/ahb_lite_mem_ws.sv
// AHB-Lite on-chip RAM slave: byte-lane writes, programmable data-phase wait states,
// write->read forwarding and two-cycle ERROR responses.
module ahb_lite_mem_ws #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic [31:0] HADDR,
    input  logic [2:0]  HBURST,
    input  logic        HSEL,
    input  logic [2:0]  HSIZE,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA
);

    localparam int unsigned WordBits = ADDR_WIDTH - 2;
    localparam int unsigned Depth    = 1 << WordBits;
    localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

    typedef enum logic [2:0] {StIdle, StWait, StLast, StErr1, StErr2} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [WordBits-1:0] word_q;
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                write_q;
    logic [31:0]         rdata_q, rdata_d;

    logic [31:0]         mem [Depth];

    logic                accept;
    logic                req_valid;
    logic                commit;
    logic                load_rd;
    logic                rd_is_read;
    logic [WordBits-1:0] rd_word;
    logic [3:0]          be;

    // Bits that only the interconnect cares about.
    logic unused_bits;
    assign unused_bits = ^{HBURST, HADDR[31:ADDR_WIDTH], HTRANS[0]};

    assign accept    = HSEL && HTRANS[1] && HREADY && HREADYOUT;
    assign req_valid = (HSIZE == 3'd0) ||
                       (HSIZE == 3'd1 && !HADDR[0]) ||
                       (HSIZE == 3'd2 && HADDR[1:0] == 2'b00);
    assign commit    = (state_q == StLast) && write_q;

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        unique case (state_q)
            StWait:  HREADYOUT = 1'b0;
            StErr1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            StErr2:  HRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StWait: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StLast;
                end
            end
            StErr1: state_d = StErr2;
            default: begin
                if (!accept) begin
                    state_d = StIdle;
                end else if (!req_valid) begin
                    state_d = StErr1;
                end else if (WAIT_STATES == 0) begin
                    state_d = StLast;
                end else begin
                    state_d = StWait;
                    cnt_d   = WaitInit;
                end
            end
        endcase
    end

    // Lane enables of the transfer in its data phase; only valid sizes ever reach LAST.
    always_comb begin
        be = 4'b0000;
        case (size_q)
            2'd0:    be[lane_q] = 1'b1;
            2'd1:    be = lane_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    // Read data is captured on entry to LAST; a write committing on the same edge
    // to the same word is merged in so a back-to-back read sees the new bytes.
    always_comb begin
        rd_word    = (state_q == StWait) ? word_q : HADDR[ADDR_WIDTH-1:2];
        rd_is_read = (state_q == StWait) ? !write_q : !HWRITE;
        load_rd    = (state_d == StLast) && rd_is_read;
        rdata_d    = mem[rd_word];
        for (int i = 0; i < 4; i++) begin
            if (commit && be[i] && (word_q == rd_word)) begin
                rdata_d[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            word_q  <= '0;
            lane_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                word_q  <= HADDR[ADDR_WIDTH-1:2];
                lane_q  <= HADDR[1:0];
                size_q  <= HSIZE[1:0];
                write_q <= HWRITE;
            end
            if (load_rd) begin
                rdata_q <= rdata_d;
            end
        end
    end

    // RAM contents survive reset; an aborted transfer never reaches LAST so never commits.
    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_q][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

    assign HRDATA = rdata_q;

endmodule

// File: tb/tb_ahb_lite_mem_ws.sv
// Bench for ahb_lite_mem_ws: a zero-wait and a three-wait instance on a shared bus,
// a transaction-level reference model, and a per-cycle output compare.
module tb_ahb_lite_mem_ws;

    typedef struct packed {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic        last;
    } xfer_t;

    logic        HCLK;
    logic        HRESET;
    logic [31:0] haddr;
    logic [2:0]  hburst;
    logic [1:0]  hsel;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [1:0]  rdyo;
    logic [1:0]  resp;
    logic [31:0] rdata [2];

    ahb_lite_mem_ws #(.ADDR_WIDTH(10), .WAIT_STATES(0)) u_dut0 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel[0]),
        .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdyo[0]),
        .HREADYOUT(rdyo[0]), .HRESP(resp[0]), .HRDATA(rdata[0])
    );

    ahb_lite_mem_ws #(.ADDR_WIDTH(10), .WAIT_STATES(3)) u_dut1 (
        .HCLK(HCLK), .HRESET(HRESET), .HADDR(haddr), .HBURST(hburst), .HSEL(hsel[1]),
        .HSIZE(hsize), .HTRANS(htrans), .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(rdyo[1]),
        .HREADYOUT(rdyo[1]), .HRESP(resp[1]), .HRDATA(rdata[1])
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // Model state: expected {ready,resp} and read data keyed by cycle*2+instance.
    logic [1:0]  sched [int];
    logic [31:0] dsched [int];
    logic [31:0] mem_m [int];
    logic [31:0] exp_data [2];
    int          lo_cnt [2];
    int          err_cnt [2];
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          chk_en = 1'b0;
    xfer_t       seq_q [$];
    int          ck;
    logic [1:0]  ce;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic xfer_t mk(input logic sel, input logic [1:0] trans,
                                 input logic [31:0] addr, input logic [2:0] size,
                                 input logic write, input logic [31:0] wdata);
        xfer_t x;
        x.sel   = sel;
        x.trans = trans;
        x.addr  = addr;
        x.size  = size;
        x.write = write;
        x.wdata = wdata;
        x.last  = 1'b0;
        return x;
    endfunction

    task automatic wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] d);
        seq_q.push_back(mk(1'b1, 2'b10, addr, size, 1'b1, d));
    endtask

    task automatic rd(input logic [31:0] addr, input logic [2:0] size);
        seq_q.push_back(mk(1'b1, 2'b10, addr, size, 1'b0, 32'h0));
    endtask

    function automatic bit legal(input logic [31:0] a, input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd1 && a % 2 == 0) || (s == 3'd2 && a % 4 == 0);
    endfunction

    // Whole-transfer view: errors take two cycles, OKAY takes ws+1 cycles with the
    // read word visible from the last one; writes land in the model at acceptance.
    task automatic model_accept(input int d, input xfer_t a, input int e);
        int ws;
        int w;
        logic [31:0] v;
        ws = (d == 0) ? 0 : 3;
        if (!legal(a.addr, a.size)) begin
            sched[e*2 + d]     = 2'b01;
            sched[(e+1)*2 + d] = 2'b11;
        end else begin
            for (int k = 0; k < ws; k++) sched[(e+k)*2 + d] = 2'b00;
            w = d*1000 + int'(a.addr % 1024) / 4;
            if (a.write) begin
                v = mem_m.exists(w) ? mem_m[w] : 32'h0;
                for (int i = 0; i < 4; i++) begin
                    if (a.size == 3'd2 || (a.size == 3'd1 && i/2 == int'(a.addr[1])) ||
                        (a.size == 3'd0 && i == int'(a.addr[1:0])))
                        v[8*i +: 8] = a.wdata[8*i +: 8];
                end
                mem_m[w] = v;
            end else begin
                dsched[(e+ws)*2 + d] = mem_m.exists(w) ? mem_m[w] : 32'hx;
            end
        end
    endtask

    task automatic drive_addr(input int d, input xfer_t a);
        hsel = 2'b00;
        if (a.sel) hsel[d] = 1'b1;
        haddr  = a.addr;
        htrans = a.trans;
        hsize  = a.size;
        hwrite = a.write;
    endtask

    // Pipelined master: address of the next transfer overlaps the current data phase.
    task automatic run(input int d);
        xfer_t a;
        xfer_t term;
        logic  r;
        int    guard;
        term = mk(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 32'h0);
        term.last = 1'b1;
        seq_q.push_back(term);
        a = seq_q.pop_front();
        drive_addr(d, a);
        guard = 0;
        forever begin
            @(negedge HCLK);
            r = rdyo[d];
            @(posedge HCLK);
            #1;
            if (r) begin
                if (a.last) break;
                if (a.sel && a.trans[1]) model_accept(d, a, cyc);
                hwdata = a.wdata;
                a = seq_q.pop_front();
                drive_addr(d, a);
            end
            guard++;
            if (guard > 200) begin
                n_cmp++;
                n_bad++;
                $display("FAIL bus timeout dut%0d: ready stuck low, got %0d, expected <= 200 cycles",
                         d, guard);
                seq_q.delete();
                drive_addr(d, term);
                break;
            end
        end
    endtask

    always @(negedge HCLK) begin
        if (!HRESET) begin
            for (int d = 0; d < 2; d++) begin
                if (!rdyo[d]) lo_cnt[d]++;
                if (resp[d]) err_cnt[d]++;
            end
        end
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                ck = cyc*2 + d;
                ce = sched.exists(ck) ? sched[ck] : 2'b10;
                if (dsched.exists(ck)) exp_data[d] = dsched[ck];
                check($sformatf("HREADYOUT dut%0d", d), {31'h0, rdyo[d]}, {31'h0, ce[1]});
                check($sformatf("HRESP dut%0d", d), {31'h0, resp[d]}, {31'h0, ce[0]});
                check($sformatf("HRDATA dut%0d", d), rdata[d], exp_data[d]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got %0d cycles, expected the run to finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1;
        hsel   = 2'b00;
        haddr  = 32'h0;
        hburst = 3'd0;
        hsize  = 3'd0;
        htrans = 2'b00;
        hwrite = 1'b0;
        hwdata = 32'h0;
        exp_data[0] = 32'h0;
        exp_data[1] = 32'h0;
        lo_cnt  = '{0, 0};
        err_cnt = '{0, 0};

        repeat (2) @(posedge HCLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset HREADYOUT dut%0d", d), {31'h0, rdyo[d]}, 32'h1);
            check($sformatf("reset HRESP dut%0d", d), {31'h0, resp[d]}, 32'h0);
            check($sformatf("reset HRDATA dut%0d", d), rdata[d], 32'h0);
        end
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk_en = 1'b1;

        // Zero-wait write then read of word 0.
        lo_cnt[0] = 0;
        wr(32'h0, 3'd2, 32'hDEADBEEF);
        rd(32'h0, 3'd2);
        run(0);
        check("t1 read data", rdata[0], 32'hDEADBEEF);
        check("t1 wait cycles", lo_cnt[0], 32'd0);

        // Byte writes with junk on the idle lanes, then an immediate forwarded read.
        wr(32'h4, 3'd2, 32'hDEADBEEF);
        wr(32'h5, 3'd0, 32'h5A5A115A);
        wr(32'h6, 3'd0, 32'h5A225A5A);
        rd(32'h4, 3'd2);
        run(0);
        check("t2 forwarded read", rdata[0], 32'hDE2211EF);

        // Three wait states, half-word write, back-to-back reads.
        lo_cnt[1] = 0;
        wr(32'h10, 3'd2, 32'h0BADF00D);
        wr(32'h14, 3'd2, 32'h76543210);
        wr(32'h12, 3'd1, 32'hBEEF7777);
        rd(32'h14, 3'd2);
        rd(32'h10, 3'd2);
        run(1);
        check("t3 half-merged read", rdata[1], 32'hBEEFF00D);
        check("t3 wait cycles", lo_cnt[1], 32'd15);

        // Misaligned / oversized transfers error out; word 0 still readable via an alias.
        lo_cnt[0]  = 0;
        err_cnt[0] = 0;
        rd(32'h4, 3'd2);
        wr(32'h2, 3'd2, 32'hFFFFFFFF);
        rd(32'h1, 3'd1);
        rd(32'h0, 3'd3);
        rd(32'h1000, 3'd2);
        run(0);
        check("t4 error cycles", err_cnt[0], 32'd6);
        check("t4 stall cycles", lo_cnt[0], 32'd3);
        check("t4 word0 intact", rdata[0], 32'hDEADBEEF);

        // BUSY, deselected and IDLE writes must not touch memory or stall.
        lo_cnt[0] = 0;
        rd(32'h4, 3'd2);
        seq_q.push_back(mk(1'b1, 2'b01, 32'h0, 3'd2, 1'b1, 32'h0));
        seq_q.push_back(mk(1'b0, 2'b10, 32'h0, 3'd2, 1'b1, 32'h0));
        seq_q.push_back(mk(1'b1, 2'b00, 32'h0, 3'd2, 1'b1, 32'h0));
        rd(32'h0, 3'd2);
        run(0);
        check("t5 no stray write", rdata[0], 32'hDEADBEEF);
        check("t5 wait cycles", lo_cnt[0], 32'd0);

        // Reset in the middle of a waited write aborts it.
        wr(32'h40, 3'd2, 32'h12345678);
        run(1);
        chk_en = 1'b0;
        drive_addr(1, mk(1'b1, 2'b10, 32'h40, 3'd2, 1'b1, 32'h0));
        @(posedge HCLK);
        #1;
        hwdata = 32'hCAFEF00D;
        drive_addr(1, mk(1'b0, 2'b00, 32'h0, 3'd0, 1'b0, 32'h0));
        @(negedge HCLK);
        check("t6 in wait state", {31'h0, rdyo[1]}, 32'h0);
        #2;
        HRESET = 1'b1;
        #1;
        check("t6 reset HREADYOUT", {31'h0, rdyo[1]}, 32'h1);
        check("t6 reset HRESP", {31'h0, resp[1]}, 32'h0);
        check("t6 reset HRDATA dut1", rdata[1], 32'h0);
        check("t6 reset HRDATA dut0", rdata[0], 32'h0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        exp_data[0] = 32'h0;
        exp_data[1] = 32'h0;
        chk_en = 1'b1;
        rd(32'h40, 3'd2);
        run(1);
        check("t6 aborted write", rdata[1], 32'h12345678);

        repeat (2) @(posedge HCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
